// File: rtl/mem_writein_top.sv
// Receive end of the merged memory readout stream: decodes tag/BX of each word and writes
// the payload into one of NMEM paged memories, reporting per-memory item counts per event.
module mem_writein_top #(
    parameter int unsigned NMEM   = 12,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DAT_W  = 44
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_event,
    input  logic [2:0]                   BX,
    input  logic [51:0]                  mem_dat_stream,
    input  logic                         valid,
    output logic [NMEM-1:0]              wr_en,
    output logic [NMEM*(ADDR_W+1)-1:0]   wr_addr,
    output logic [DAT_W-1:0]             wr_dat,
    output logic [NMEM*ADDR_W-1:0]       number_out,
    output logic                         count_valid,
    output logic [NMEM-1:0]              overflow,
    output logic                         bx_err
);

    logic                              s1_valid_q;
    logic [51:0]                       s1_dat_q;
    logic [NMEM-1:0][ADDR_W-1:0]       count_q, count_d, cnt_eff;
    logic [NMEM-1:0][ADDR_W-1:0]       number_out_q;
    logic [NMEM-1:0][ADDR_W:0]         wr_addr_q, wr_addr_d;
    logic [NMEM-1:0]                   wr_en_q, wr_en_d;
    logic [NMEM-1:0]                   overflow_q, ovf_set;
    logic [DAT_W-1:0]                  wr_dat_q;
    logic                              count_valid_q;
    logic                              bx_err_q, bx_bad;
    logic                              page_q, page_eff;
    logic [2:0]                        exp_bx_q, bx_eff;
    logic [3:0]                        tag;

    assign tag = s1_dat_q[47:44];

    // The word in stage 1 at a new_event edge already belongs to the new event.
    always_comb begin
        cnt_eff   = new_event ? '0 : count_q;
        page_eff  = new_event ? ~page_q : page_q;
        bx_eff    = new_event ? BX : exp_bx_q;
        bx_bad    = s1_valid_q && (32'(tag) >= NMEM || s1_dat_q[50:48] != bx_eff
                                   || s1_dat_q[51]);
        count_d   = cnt_eff;
        wr_en_d   = '0;
        ovf_set   = '0;
        wr_addr_d = '0;
        for (int unsigned i = 0; i < NMEM; i++) begin
            wr_addr_d[i] = {page_eff, cnt_eff[i]};
            if (s1_valid_q && !bx_bad && 32'(tag) == i) begin
                // All-ones count means the page is full; the last usable address is one below.
                if (cnt_eff[i] == '1) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    wr_en_d[i] = 1'b1;
                    count_d[i] = cnt_eff[i] + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_dat_q      <= '0;
            count_q       <= '0;
            number_out_q  <= '0;
            wr_addr_q     <= '0;
            wr_en_q       <= '0;
            wr_dat_q      <= '0;
            overflow_q    <= '0;
            bx_err_q      <= 1'b0;
            count_valid_q <= 1'b0;
            page_q        <= 1'b0;
            exp_bx_q      <= '0;
        end else begin
            s1_valid_q    <= valid;
            s1_dat_q      <= mem_dat_stream;
            count_q       <= count_d;
            wr_addr_q     <= wr_addr_d;
            wr_en_q       <= wr_en_d;
            wr_dat_q      <= s1_dat_q[DAT_W-1:0];
            page_q        <= page_eff;
            exp_bx_q      <= bx_eff;
            count_valid_q <= new_event;
            overflow_q    <= (new_event ? '0 : overflow_q) | ovf_set;
            bx_err_q      <= (new_event ? 1'b0 : bx_err_q) | bx_bad;
            // count_q already includes any write sitting in stage 2.
            if (new_event) begin
                number_out_q <= count_q;
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_dat      = wr_dat_q;
    assign number_out  = number_out_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;
    assign bx_err      = bx_err_q;

endmodule

// File: tb/tb_mem_writein_top.sv
// Scoreboard bench for mem_writein_top: an event-level model queues expected writes and
// reports; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_writein_top;

    localparam int NMEM = 12;
    localparam int AW   = 6;
    localparam int DW   = 44;

    typedef struct packed {
        logic [3:0]    mem;
        logic [AW:0]   addr;
        logic [DW-1:0] dat;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  new_event = 1'b0;
    logic [2:0]            BX = '0;
    logic [51:0]           mem_dat_stream = '0;
    logic                  valid = 1'b0;
    logic [NMEM-1:0]       wr_en;
    logic [NMEM*(AW+1)-1:0] wr_addr;
    logic [DW-1:0]         wr_dat;
    logic [NMEM*AW-1:0]    number_out;
    logic                  count_valid;
    logic [NMEM-1:0]       overflow;
    logic                  bx_err;

    mem_writein_top dut (
        .clk(clk), .reset(reset), .new_event(new_event), .BX(BX),
        .mem_dat_stream(mem_dat_stream), .valid(valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_dat(wr_dat), .number_out(number_out), .count_valid(count_valid),
        .overflow(overflow), .bx_err(bx_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int              m_count[NMEM];
    logic            m_page = 1'b0;
    logic [2:0]      m_bx = '0;
    logic [NMEM-1:0] m_ovf = '0;
    logic            m_bxerr = 1'b0;
    logic            pend_v = 1'b0;
    logic [51:0]     pend_w = '0;
    wr_t             wr_q[$];
    logic [NMEM*AW-1:0] rep_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [51:0] mk(input logic b51, input logic [2:0] b, input logic [3:0] t,
                                       input logic [43:0] p);
        return {b51, b, t, p};
    endfunction

    task automatic model_edge(input logic ne, input logic [2:0] b, input logic v,
                              input logic [51:0] w);
        int t;
        if (ne) begin
            logic [NMEM*AW-1:0] rep;
            rep = '0;
            for (int i = 0; i < NMEM; i++) begin
                rep[i*AW +: AW] = AW'(m_count[i]);
                m_count[i] = 0;
            end
            rep_q.push_back(rep);
            m_page  = ~m_page;
            m_bx    = b;
            m_ovf   = '0;
            m_bxerr = 1'b0;
        end
        if (pend_v) begin
            t = int'(pend_w[47:44]);
            if (pend_w[51] || t >= NMEM || pend_w[50:48] != m_bx) begin
                m_bxerr = 1'b1;
            end else if (m_count[t] == (1 << AW) - 1) begin
                m_ovf[t] = 1'b1;
            end else begin
                wr_q.push_back('{mem: 4'(t), addr: {m_page, AW'(m_count[t])},
                                 dat: pend_w[43:0]});
                m_count[t]++;
            end
        end
        pend_v = v;
        pend_w = w;
    endtask

    task automatic step(input logic v, input logic [51:0] w, input logic ne, input logic [2:0] b);
        valid = v;
        mem_dat_stream = w;
        new_event = ne;
        BX = b;
        @(posedge clk);
        model_edge(ne, b, v, w);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        valid = 1'b0;
        new_event = 1'b0;
        for (int i = 0; i < NMEM; i++) m_count[i] = 0;
        m_page = 1'b0; m_bx = '0; m_ovf = '0; m_bxerr = 1'b0; pend_v = 1'b0;
        wr_q.delete();
        rep_q.delete();
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (wr_en != '0) begin
            chk("wr_en_onehot", 128'($countones(wr_en)), 128'(1));
            for (int i = 0; i < NMEM; i++) begin
                if (wr_en[i]) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write_mem", 128'(i), 128'hFFFF);
                    end else begin
                        wr_t e, a;
                        e = wr_q.pop_front();
                        a = '{mem: 4'(i), addr: wr_addr[i*(AW+1) +: AW+1], dat: wr_dat};
                        chk("write", 128'(a), 128'(e));
                    end
                end
            end
        end
        if (count_valid) begin
            if (rep_q.size() == 0) chk("unexpected_count_valid", 128'(1), 128'(0));
            else chk("number_out", 128'(number_out), 128'(rep_q.pop_front()));
        end
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("bx_err", 128'(bx_err), 128'(m_bxerr));
    end

    initial begin
        logic [2:0] rb;
        logic       ne;
        for (int i = 0; i < NMEM; i++) m_count[i] = 0;
        // 1: reset and a simple three-word event on tag 2
        do_reset(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", 128'(wr_en), 128'(0));
        chk("rst_wr_addr", 128'(wr_addr), 128'(0));
        chk("rst_wr_dat", 128'(wr_dat), 128'(0));
        chk("rst_number_out", 128'(number_out), 128'(0));
        chk("rst_count_valid", 128'(count_valid), 128'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b0, '0, 1'b1, 3'd5);
        step(1'b1, mk(0, 5, 2, 44'hA), 1'b0, '0);
        step(1'b1, mk(0, 5, 2, 44'hB), 1'b0, '0);
        step(1'b1, mk(0, 5, 2, 44'hC), 1'b0, '0);
        idle(3);
        // 2: interleaved tags with gaps
        step(1'b0, '0, 1'b1, 3'd5);
        step(1'b1, mk(0, 5, 0, 44'h10), 1'b0, '0); idle(1);
        step(1'b1, mk(0, 5, 11, 44'h11), 1'b0, '0); idle(1);
        step(1'b1, mk(0, 5, 0, 44'h12), 1'b0, '0); idle(1);
        step(1'b1, mk(0, 5, 11, 44'h13), 1'b0, '0); idle(2);
        // 3: fill tag 4 past its last address
        step(1'b0, '0, 1'b1, 3'd5);
        for (int i = 0; i < 70; i++) step(1'b1, mk(0, 5, 4, 44'(i)), 1'b0, '0);
        idle(2);
        chk("overflow4_set", 128'(overflow[4]), 128'(1));
        step(1'b0, '0, 1'b1, 3'd5);
        idle(1);
        chk("overflow_cleared", 128'(overflow), 128'(0));
        // 4: BX mismatch and out-of-range tag
        step(1'b1, mk(0, 3, 1, 44'h20), 1'b0, '0);
        step(1'b1, mk(0, 5, 13, 44'h21), 1'b0, '0);
        step(1'b1, mk(1, 5, 1, 44'h22), 1'b0, '0);
        idle(2);
        chk("bx_err_set", 128'(bx_err), 128'(1));
        // 5: word in stage 1 and word in stage 2 at a new_event edge
        step(1'b0, '0, 1'b1, 3'd5);
        step(1'b1, mk(0, 5, 1, 44'h30), 1'b0, '0);
        step(1'b1, mk(0, 6, 1, 44'h31), 1'b0, '0);
        step(1'b0, '0, 1'b1, 3'd6);
        idle(2);
        step(1'b0, '0, 1'b1, 3'd6);
        step(1'b0, '0, 1'b1, 3'd6);
        idle(2);
        // 6: reset mid-burst, then writes restart at {0,0}
        step(1'b0, '0, 1'b1, 3'd2);
        for (int i = 0; i < 4; i++) step(1'b1, mk(0, 2, 7, 44'h40 + 44'(i)), 1'b0, '0);
        do_reset(2);
        for (int i = 0; i < 3; i++) step(1'b1, mk(0, 0, 7, 44'h50 + 44'(i)), 1'b0, '0);
        idle(2);
        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            ne = ($urandom_range(0, 24) == 0);
            rb = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 2) != 0),
                 mk(($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : m_bx,
                    ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                : 4'($urandom_range(0, 11)),
                    {12'($urandom), 32'($urandom)}),
                 ne, rb);
        end
        idle(3);
        step(1'b0, '0, 1'b1, 3'd0);
        idle(3);
        chk("writes_outstanding", 128'(wr_q.size()), 128'(0));
        chk("reports_outstanding", 128'(rep_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_writein_top.md
Name: mem_writein_top

Overview:
- Receive end of the merged memory readout stream.
- Takes the single gapped 52-bit stream plus valid bit, decodes the per-word source tag and BX, and writes each payload into the matching one of NMEM destination memories.
- Maintains one write-address counter per destination and reports per-memory item counts at each event boundary, in the same form the readout side consumes as its starting item counts.
- Sits at the far end of a link, just before the destination memory array.

Parameters:
NMEM, 12, number of destination memories (source tag 0..NMEM-1)
ADDR_W, 6, low address bits per memory (depth 2^ADDR_W words per page)
DAT_W, 44, payload width written to memory

Ports:
clk  in  1  processing clock
reset  in  1  asynchronous, active-low reset
new_event  in  1  one-cycle pulse: close current event, start next
BX  in  3  BX number of the event being started, sampled on new_event
mem_dat_stream  in  52  merged stream: [51] reserved(0), [50:48] BX, [47:44] source tag, [43:0] payload
valid  in  1  mem_dat_stream holds a valid word this cycle
wr_en  out  NMEM  per-memory write enable, one-hot or zero
wr_addr  out  NMEM*(ADDR_W+1)  per-memory address, slice i = {page, count_i}
wr_dat  out  DAT_W  shared write data
number_out  out  NMEM*ADDR_W  item counts of the last closed event, slice i for memory i
count_valid  out  1  one-cycle pulse when number_out updates
overflow  out  NMEM  sticky per event: a word to memory i was dropped because memory i was full
bx_err  out  1  sticky per event: a word was dropped on BX or tag mismatch

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - Counters 0, page 0, expected BX 0.
  - Registered stage cleared.
- Stage 1 (registered):
  - Capture valid, mem_dat_stream.
  - Decode tag and check BX against expected BX.
- Stage 2 (write):
  - wr_en[tag], wr_dat, wr_addr driven from registers.
  - Latency: valid high at edge N gives wr_en high for the cycle after edge N+1 (2 registers).
  - wr_addr slice i = {page, count_i}. The value count_i has before increment is presented with the write.
- Accept rule for a stage-1 word (all must hold):
  - tag < NMEM
  - BX field == expected BX
  - bit 51 == 0
  - count_tag < 2^ADDR_W-1
  - On accept: wr_en[tag]=1, count_tag++.
- Drop rules:
  - Tag or BX mismatch or bit 51 set: no write; bx_err=1.
  - count_tag == 2^ADDR_W-1 (63, full): no write; overflow[tag]=1.
  - Last usable address is 62; count saturates at 63, which encodes "full".
- Event close, on new_event=1 at edge E:
  - number_out <= counts, including any accepted write already in stage 2.
  - count_valid=1 for one cycle after E.
  - All counts <= 0.
  - page <= ~page.
  - expected BX <= BX.
  - overflow, bx_err cleared.
- Simultaneous events:
  - A word in stage 1 at edge E is judged against the new expected BX and the new page. Upstream holds off output for 2 cycles after new_event, so a word arriving here belongs to the new event by construction.
  - A word in stage 2 at E is written with the old page and counted in number_out.
  - new_event on consecutive cycles: each pulse closes an event; the second reports all-zero counts.
- new_event with valid never asserted: reports zeros, page still toggles.
- reset asserted mid-event: all state lost, no count_valid pulse.
- No backpressure: valid words are never stalled, only dropped per the rules above.

Test Plan:
1. Reset low 3 cycles -> all outputs 0. new_event with BX=5, then 3 words: tag 2, BX 5, payloads 0xA,0xB,0xC -> wr_en[2] on 3 consecutive cycles, addr slice 2 = 0,1,2, page 1. Next new_event -> number_out slice 2 = 3, others 0, count_valid 1 cycle.
2. Interleaved tags 0,11,0,11 with gaps (valid low between) -> wr_addr 0,0,1,1 on respective slices. Close -> counts 2 and 2.
3. 70 words to tag 4 -> 63 writes at addresses 0..62, overflow[4]=1 from word 64. Close -> number_out slice 4 = 63, overflow cleared after close.
4. Word with BX=3 while expected 5, and a word with tag 13 -> no wr_en, bx_err=1. Counts unchanged.
5. valid coincident with new_event (BX 5->6, word BX=6) -> word written at count 0, new page. Word in stage 2 at the same edge is counted in the closing report.
6. reset pulsed low mid-burst of tag 7 -> wr_en drops immediately, count 0, page 0. Next event starts at address {0,0}.
